// File: rtl/fwg_pkg.sv
// Shared definitions for the fixed-weight vector generator.
//   state_t      : control FSM states
//   clog2        : ceiling log2, never below 1 so derived widths stay legal
//   BO_*         : in-word bit order selectors
`timescale 1ns/1ps
package fwg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WAIT_LOC,
      RMW_RD,
      RMW_WR,
      DONE
   } state_t;

   localparam int BO_MSB_FIRST = 0;
   localparam int BO_LSB_FIRST = 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/fwg_bitmem.sv
// Dual-port WIDTH x DEPTH bit RAM with synchronous reads.
//   Port A (a_*) : read/modify/write port owned by the control FSM.
//   Port B (b_*) : read-out port; b_q holds unless b_en, is 0 after reset,
//                  and returns 0 for addresses beyond the last word.
`timescale 1ns/1ps
module fwg_bitmem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 218,
   parameter int LOGD  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_en,
   input  logic             a_we,
   input  logic [LOGD-1:0]  a_addr,
   input  logic [WIDTH-1:0] a_wdata,
   output logic [WIDTH-1:0] a_q,
   input  logic             b_en,
   input  logic [LOGD-1:0]  b_addr,
   output logic [WIDTH-1:0] b_q
);

   localparam logic [LOGD:0] DEPTH_L = (LOGD+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are intentionally not reset; every run clears them first.
   always_ff @(posedge clk) begin
      if (a_en) begin
         if (a_we) mem[a_addr] <= a_wdata;
         a_q <= mem[a_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         b_q <= '0;
      else if (b_en)
         b_q <= ({1'b0, b_addr} < DEPTH_L) ? mem[b_addr] : '0;
   end

endmodule

// File: rtl/fixed_weight_vec_gen.sv
// Fixed-weight error vector builder.
//   start/busy/done/collision : run control; done and collision are 1-cycle pulses
//   loc/loc_valid/loc_ready   : location stream; locations >= N are dropped and counted
//   weight                    : distinct bits set in the current run
//   oor_cnt                   : out-of-range locations dropped this run (saturating)
//   rd_en/rd_addr/rd_data     : independent word read-out, 1-cycle latency
`timescale 1ns/1ps
module fixed_weight_vec_gen
   import fwg_pkg::*;
#(
   parameter int M         = 13,
   parameter int N         = 6960,
   parameter int WIDTH     = 32,
   parameter int DEPTH     = (N + WIDTH - 1) / WIDTH,
   parameter int TAU       = 119,
   parameter int BIT_ORDER = BO_MSB_FIRST,
   parameter int LOGD      = clog2(DEPTH),
   parameter int LOGTAU    = clog2(TAU + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [M-1:0]      loc,
   input  logic              loc_valid,
   output logic              loc_ready,
   output logic              busy,
   output logic              done,
   output logic              collision,
   output logic [LOGTAU-1:0] weight,
   output logic [15:0]       oor_cnt,
   input  logic              rd_en,
   input  logic [LOGD-1:0]   rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   localparam logic [M:0]        N_L       = (M+1)'(N);
   localparam logic [LOGTAU-1:0] TAU_L     = LOGTAU'(TAU);
   localparam logic [LOGD-1:0]   LAST_ADDR = LOGD'(DEPTH - 1);
   localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);

   state_t            state, nxt;
   logic [LOGD-1:0]   clr_addr, word, a_addr;
   logic [WIDTH-1:0]  mask, loc_mask, a_wdata, a_q;
   logic [M-1:0]      loc_bit;
   logic              a_en, a_we, in_range, hit;
   logic [LOGTAU-1:0] weight_inc;

   assign in_range   = {1'b0, loc} < N_L;
   assign loc_bit    = loc % M'(WIDTH);
   assign loc_mask   = (BIT_ORDER == BO_LSB_FIRST) ? (ONE << loc_bit)
                                                   : (ONE << (M'(WIDTH - 1) - loc_bit));
   assign hit        = (a_q & mask) != '0;
   assign weight_inc = weight + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (start) nxt = CLEAR;
         CLEAR:    if (clr_addr == LAST_ADDR) nxt = WAIT_LOC;
         WAIT_LOC: if (loc_valid && in_range) nxt = RMW_RD;
         RMW_RD:   nxt = RMW_WR;
         RMW_WR:   if (hit) nxt = IDLE;
                   else if (weight_inc == TAU_L) nxt = DONE;
                   else nxt = WAIT_LOC;
         DONE:     nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   // Pulses are masked during reset so an aborted run never reports an outcome.
   always_comb begin
      loc_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      collision = 1'b0;
      a_en      = 1'b0;
      a_we      = 1'b0;
      a_addr    = word;
      a_wdata   = a_q | mask;
      case (state)
         CLEAR: begin
            busy    = 1'b1;
            a_en    = 1'b1;
            a_we    = 1'b1;
            a_addr  = clr_addr;
            a_wdata = '0;
         end
         WAIT_LOC: begin
            busy      = 1'b1;
            loc_ready = 1'b1;
         end
         RMW_RD: begin
            busy = 1'b1;
            a_en = 1'b1;
         end
         RMW_WR: begin
            busy      = !hit;
            collision = hit && !rst;
            a_en      = !hit;
            a_we      = !hit;
         end
         DONE:    done = !rst;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         weight   <= '0;
         oor_cnt  <= '0;
         clr_addr <= '0;
         word     <= '0;
         mask     <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               weight   <= '0;
               oor_cnt  <= '0;
               clr_addr <= '0;
            end
            CLEAR: clr_addr <= clr_addr + 1'b1;
            WAIT_LOC: if (loc_valid) begin
               if (in_range) begin
                  word <= LOGD'(loc / M'(WIDTH));
                  mask <= loc_mask;
               end else if (oor_cnt != 16'hFFFF) begin
                  oor_cnt <= oor_cnt + 16'd1;
               end
            end
            RMW_WR: if (!hit) weight <= weight_inc;
            default: ;
         endcase
      end
   end

   fwg_bitmem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LOGD  (LOGD)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .a_en    (a_en),
      .a_we    (a_we),
      .a_addr  (a_addr),
      .a_wdata (a_wdata),
      .a_q     (a_q),
      .b_en    (rd_en),
      .b_addr  (rd_addr),
      .b_q     (rd_data)
   );

endmodule
